// File: rtl/mem_nport_rr.sv
// Shared N-channel scratch RAM with round-robin arbitration, byte-enable
// writes, out-of-range error responses and a post-reset zero-fill.
module mem_nport_rr #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned BE_WIDTH   = WIDTH / 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_CH-1:0]              valid_i,
    input  logic [NUM_CH-1:0]              wr_rd_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_CH*WIDTH-1:0]        wdata_i,
    input  logic [NUM_CH*BE_WIDTH-1:0]     be_i,
    output logic [NUM_CH*WIDTH-1:0]        rdata_o,
    output logic [NUM_CH-1:0]              ready_o,
    output logic [NUM_CH-1:0]              err_o,
    output logic                           busy_o
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned AW1  = ADDR_WIDTH + 1;

    localparam logic [AW1-1:0]        DEPTH_X  = AW1'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CH_W-1:0]       LAST_CH  = CH_W'(NUM_CH - 1);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  fill_cnt;
    logic [CH_W-1:0]        rr_ptr;

    logic [NUM_CH-1:0]      eligible;
    logic                   gnt_valid;
    logic [CH_W-1:0]        gnt_idx;
    int unsigned            cand;

    logic [ADDR_WIDTH-1:0]  g_addr;
    logic                   g_wr;
    logic [WIDTH-1:0]       g_wdata;
    logic [BE_WIDTH-1:0]    g_be;
    logic                   g_in_range;

    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_waddr;
    logic [WIDTH-1:0]       mem_wdata;
    logic [BE_WIDTH-1:0]    mem_be;

    logic [WIDTH-1:0]       mem [DEPTH];

    assign busy_o = (state == S_INIT);

    // A channel whose completion is showing this cycle is masked from re-grant.
    assign eligible = (state == S_RUN) ? (valid_i & ~ready_o) : '0;

    // Round-robin pick: first eligible channel at or after the pointer.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = (32'(rr_ptr) + i) % NUM_CH;
            if (!gnt_valid && eligible[CH_W'(cand)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = CH_W'(cand);
            end
        end
    end

    assign g_addr     = addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign g_wr       = wr_rd_i[gnt_idx];
    assign g_wdata    = wdata_i[gnt_idx*WIDTH +: WIDTH];
    assign g_be       = be_i[gnt_idx*BE_WIDTH +: BE_WIDTH];
    assign g_in_range = (AW1'(g_addr) < DEPTH_X);

    // Storage write port: zero-fill during INIT, granted in-range writes in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (state == S_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = fill_cnt;
            mem_be    = '1;
        end else if (gnt_valid && g_wr && g_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = g_addr;
            mem_wdata = g_wdata;
            mem_be    = g_be;
        end
    end

    // Byte-lane storage update; contents survive reset until INIT rewrites them.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < BE_WIDTH; b++) begin
                if (mem_be[b]) begin
                    mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Control FSM: fill sequencing, grant execution, completion pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_INIT;
            fill_cnt <= '0;
            rr_ptr   <= '0;
            ready_o  <= '0;
            err_o    <= '0;
            rdata_o  <= '0;
        end else begin
            ready_o <= '0;
            err_o   <= '0;
            case (state)
                S_INIT: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == LAST_IDX) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (gnt_valid) begin
                        ready_o[gnt_idx] <= 1'b1;
                        err_o[gnt_idx]   <= !g_in_range;
                        if (!g_wr) begin
                            rdata_o[gnt_idx*WIDTH +: WIDTH] <= g_in_range ? mem[g_addr] : '0;
                        end
                        rr_ptr <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_nport_rr.sv
// Self-checking bench for mem_nport_rr: directed scenarios plus random
// traffic, all compared against a behavioural memory/arbitration model.
module tb_mem_nport_rr;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 500;
    localparam int unsigned AW    = 9;
    localparam int unsigned NCH   = 2;
    localparam int unsigned BEW   = WIDTH / 8;

    typedef struct packed {
        logic            wr;
        logic [AW-1:0]   addr;
        logic [WIDTH-1:0] data;
        logic [BEW-1:0]  be;
    } req_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NCH-1:0]        valid;
    logic [NCH-1:0]        wr_rd;
    logic [NCH*AW-1:0]     addr;
    logic [NCH*WIDTH-1:0]  wdata;
    logic [NCH*BEW-1:0]    be;
    logic [NCH*WIDTH-1:0]  rdata;
    logic [NCH-1:0]        ready;
    logic [NCH-1:0]        err;
    logic                  busy;

    always #5 clk = ~clk;

    mem_nport_rr #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .NUM_CH     (NCH),
        .BE_WIDTH   (BEW)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (valid),
        .wr_rd_i (wr_rd),
        .addr_i  (addr),
        .wdata_i (wdata),
        .be_i    (be),
        .rdata_o (rdata),
        .ready_o (ready),
        .err_o   (err),
        .busy_o  (busy)
    );

    // Requester side
    req_t            pend [NCH][$];
    req_t            cur  [NCH];
    logic [NCH-1:0]  cur_v;

    // Reference model
    logic [WIDTH-1:0] m_mem   [DEPTH];
    logic [WIDTH-1:0] m_rdata [NCH];
    logic [NCH-1:0]   m_ready;
    logic [NCH-1:0]   m_err;
    int               m_fill;
    int               m_ptr;

    // Observations
    logic [WIDTH:0]   comp [NCH][$];
    int               obs_log[$];
    int               edge_no;
    int               busy_drop_edge;
    int               first_ready_edge;

    int               n_pass  = 0;
    int               n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic drive();
        for (int c = 0; c < NCH; c++) begin
            valid[c]               = cur_v[c];
            wr_rd[c]               = cur[c].wr;
            addr[c*AW +: AW]       = cur[c].addr;
            wdata[c*WIDTH +: WIDTH] = cur[c].data;
            be[c*BEW +: BEW]       = cur[c].be;
        end
    endtask

    task automatic enqueue(input int c, input logic wr, input int a,
                           input logic [WIDTH-1:0] d, input logic [BEW-1:0] b);
        req_t r;
        r.wr   = wr;
        r.addr = AW'(a);
        r.data = d;
        r.be   = b;
        if (!cur_v[c]) begin
            cur[c]   = r;
            cur_v[c] = 1'b1;
        end else begin
            pend[c].push_back(r);
        end
        drive();
    endtask

    function automatic logic [WIDTH:0] take(input int c);
        if (comp[c].size() == 0) return '1;
        return comp[c].pop_front();
    endfunction

    task automatic clear_obs();
        obs_log.delete();
        for (int c = 0; c < NCH; c++) comp[c].delete();
    endtask

    // One clock: model predicts the edge, bench checks after it, requesters react.
    task automatic step();
        logic [NCH-1:0] nr = '0;
        logic [NCH-1:0] ne = '0;
        int g = -1;
        if (m_fill < int'(DEPTH)) begin
            m_fill++;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                int c = (m_ptr + k) % NCH;
                if (g < 0 && cur_v[c] && !m_ready[c]) g = c;
            end
            if (g >= 0) begin
                nr[g] = 1'b1;
                m_ptr = (g + 1) % NCH;
                if (int'(cur[g].addr) >= int'(DEPTH)) begin
                    ne[g] = 1'b1;
                    if (!cur[g].wr) m_rdata[g] = '0;
                end else if (cur[g].wr) begin
                    for (int b = 0; b < BEW; b++)
                        if (cur[g].be[b]) m_mem[cur[g].addr][8*b +: 8] = cur[g].data[8*b +: 8];
                end else begin
                    m_rdata[g] = m_mem[cur[g].addr];
                end
            end
        end
        m_ready = nr;
        m_err   = ne;

        @(posedge clk);
        #1;
        edge_no++;
        check("busy", 64'(busy), 64'(m_fill < int'(DEPTH)));
        if (!busy && busy_drop_edge == 0) busy_drop_edge = edge_no;
        if (ready != '0 && first_ready_edge == 0) first_ready_edge = edge_no;
        check("ready", 64'(ready), 64'(m_ready));
        check("err", 64'(err), 64'(m_err));
        for (int c = 0; c < NCH; c++)
            check($sformatf("rdata_ch%0d", c), 64'(rdata[c*WIDTH +: WIDTH]), 64'(m_rdata[c]));
        for (int c = 0; c < NCH; c++) begin
            if (ready[c]) begin
                obs_log.push_back(c);
                comp[c].push_back({err[c], rdata[c*WIDTH +: WIDTH]});
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (m_ready[c]) begin
                if (pend[c].size() > 0) cur[c] = pend[c].pop_front();
                else cur_v[c] = 1'b0;
            end
        end
        drive();
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((cur_v != '0 || m_ready != '0) && n < max) begin
            step();
            n++;
        end
        if (n >= max) begin
            n_total++;
            $error("FAIL drain_timeout observed=%0d cycles expected=<%0d", n, max);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cur_v = '0;
        for (int c = 0; c < NCH; c++) pend[c].delete();
        drive();
        #1;
        check("rst_ready", 64'(ready), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_busy", 64'(busy), 64'(1));
        m_fill  = 0;
        m_ptr   = 0;
        m_ready = '0;
        m_err   = '0;
        for (int c = 0; c < NCH; c++) m_rdata[c] = '0;
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
        clear_obs();
        edge_no          = 0;
        busy_drop_edge   = 0;
        first_ready_edge = 0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH:0] r;
        rst_n = 1'b1;
        cur_v = '0;
        for (int c = 0; c < NCH; c++) cur[c] = '0;
        drive();
        #2;

        // Post-reset fill with a read held through INIT
        do_reset();
        enqueue(0, 1'b0, 5, 16'h0, 2'b00);
        release_reset();
        drain(1200);
        check("fill_busy_edges", 64'(busy_drop_edge), 64'(DEPTH));
        check("fill_first_grant", 64'(first_ready_edge), 64'(DEPTH + 1));
        check("fill_rd", 64'(take(0)), 64'({1'b0, 16'h0000}));

        // Byte-enable merge seen from the other channel
        clear_obs();
        enqueue(0, 1'b1, 10, 16'hA5A5, 2'b11);
        enqueue(0, 1'b1, 10, 16'h3C00, 2'b10);
        drain(50);
        enqueue(1, 1'b0, 10, 16'h0, 2'b00);
        drain(50);
        check("be_rd", 64'(take(1)), 64'({1'b0, 16'h3CA5}));

        // Round-robin alternation with both channels saturated
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            enqueue(0, 1'b1, 100 + i, WIDTH'(16'h1000 + i), 2'b11);
            enqueue(1, 1'b1, 200 + i, WIDTH'(16'h2000 + i), 2'b11);
        end
        drain(50);
        check("rr_count", 64'(obs_log.size()), 64'(8));
        for (int i = 0; i < 8; i++) check($sformatf("rr_order%0d", i), 64'(obs_log[i]), 64'(i % 2));

        // Write on ch0 immediately followed by read on ch1 at the top address
        clear_obs();
        enqueue(0, 1'b1, 499, 16'h1234, 2'b11);
        enqueue(1, 1'b0, 499, 16'h0, 2'b00);
        drain(50);
        check("xch_order0", 64'(obs_log[0]), 64'(0));
        check("xch_order1", 64'(obs_log[1]), 64'(1));
        check("xch_rd", 64'(take(1)), 64'({1'b0, 16'h1234}));

        // Out-of-range write and read, then in-range neighbour untouched
        clear_obs();
        enqueue(0, 1'b1, 505, 16'hFFFF, 2'b11);
        enqueue(0, 1'b0, 505, 16'h0, 2'b00);
        enqueue(0, 1'b0, 499, 16'h0, 2'b00);
        drain(50);
        r = take(0);
        check("oor_wr_err", 64'(r[WIDTH]), 64'(1));
        check("oor_rd", 64'(take(0)), 64'({1'b1, 16'h0000}));
        check("oor_neighbour", 64'(take(0)), 64'({1'b0, 16'h1234}));

        // Random traffic on both channels, including out-of-range addresses
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 2) == 0 && pend[c].size() < 4) begin
                    int a;
                    a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(490, 511))
                                                    : int'($urandom_range(0, 31));
                    enqueue(c, 1'($urandom_range(0, 1)), a, WIDTH'($urandom),
                            BEW'($urandom_range(0, 3)));
                end
            end
            step();
        end
        drain(200);

        // Reset while a ch1 read completion is showing; storage re-zeroed
        enqueue(0, 1'b1, 10, 16'hBEEF, 2'b11);
        drain(50);
        enqueue(1, 1'b0, 10, 16'h0, 2'b00);
        step();
        check("pre_rst_rd", 64'(rdata[WIDTH +: WIDTH]), 64'(16'hBEEF));
        do_reset();
        enqueue(0, 1'b0, 10, 16'h0, 2'b00);
        release_reset();
        drain(1200);
        check("reinit_busy_edges", 64'(busy_drop_edge), 64'(DEPTH));
        check("reinit_rd", 64'(take(0)), 64'({1'b0, 16'h0000}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
